// File: rtl/hex_segment_reader.sv
// hex_segment_reader: collects DIGITS active-low 7-segment patterns, decodes
// each to a hex nibble and offers the assembled frame downstream with a
// sticky error flag for unrecognised patterns.
// Optional build macro HEX_SEGMENT_READER_BLANK_EN: accept the all-off
// pattern 7F as nibble 0 without flagging an error.
module hex_segment_reader #(
  parameter int DIGITS = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  input  logic                  seg_valid,
  output logic                  seg_ready,
  output logic [4*DIGITS-1:0]   value,
  output logic                  value_valid,
  input  logic                  out_ready,
  output logic                  error,
  output logic [2:0]            digit_count
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   value_q, value_d;
  logic                  error_q, error_d;
  logic [2:0]            count_q, count_d;
  logic [4:0]            decoded;

  // Returns {unrecognised, nibble}; unknown patterns decode to nibble 0.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h40: r = 5'h00;
      7'h79: r = 5'h01;
      7'h24: r = 5'h02;
      7'h30: r = 5'h03;
      7'h19: r = 5'h04;
      7'h12: r = 5'h05;
      7'h02: r = 5'h06;
      7'h78: r = 5'h07;
      7'h00: r = 5'h08;
      7'h10: r = 5'h09;
      7'h08: r = 5'h0A;
      7'h03: r = 5'h0B;
      7'h46: r = 5'h0C;
      7'h21: r = 5'h0D;
      7'h06: r = 5'h0E;
      7'h0E: r = 5'h0F;
`ifdef HEX_SEGMENT_READER_BLANK_EN
      7'h7F: r = 5'h00;
`endif
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  assign decoded = decode_seg(seg_in);

  // State register; reset wins over any accept or release on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= COLLECT;
      value_q <= '0;
      error_q <= 1'b0;
      count_q <= 3'd0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      error_q <= error_d;
      count_q <= count_d;
    end
  end

  // Next-state logic: collect digits into nibble slots, then hold until released.
  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    error_d     = error_q;
    count_d     = count_q;
    seg_ready   = (state_q == COLLECT);
    value_valid = (state_q == HOLD);
    case (state_q)
      COLLECT: begin
        if (seg_valid) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (count_q == 3'(i)) value_d[4*i +: 4] = decoded[3:0];
          end
          error_d = error_q | decoded[4];
          count_d = count_q + 3'd1;
          if (count_q == 3'(DIGITS - 1)) state_d = HOLD;
        end
      end
      HOLD: begin
        // Release edge never accepts a digit: seg_ready is low in HOLD.
        if (out_ready) begin
          state_d = COLLECT;
          value_d = '0;
          error_d = 1'b0;
          count_d = 3'd0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign value       = value_q;
  assign error       = error_q;
  assign digit_count = count_q;

endmodule

// File: tb/tb_hex_segment_reader.sv
// Directed testbench for hex_segment_reader (DIGITS=6 and DIGITS=1 instances).
module tb_hex_segment_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic        seg_valid;
  logic        seg_ready;
  logic [23:0] value;
  logic        value_valid;
  logic        out_ready;
  logic        error;
  logic [2:0]  digit_count;

  logic        reset1;
  logic [6:0]  seg_in1;
  logic        seg_valid1;
  logic        seg_ready1;
  logic [3:0]  value1;
  logic        value_valid1;
  logic        out_ready1;
  logic        error1;
  logic [2:0]  digit_count1;

  int checks = 0;
  int errors = 0;

`ifdef HEX_SEGMENT_READER_BLANK_EN
  localparam logic BLANK_ERR = 1'b0;
`else
  localparam logic BLANK_ERR = 1'b1;
`endif

  always #5 clock = ~clock;

  hex_segment_reader #(.DIGITS(6)) dut (
    .clock(clock), .reset(reset), .seg_in(seg_in), .seg_valid(seg_valid),
    .seg_ready(seg_ready), .value(value), .value_valid(value_valid),
    .out_ready(out_ready), .error(error), .digit_count(digit_count)
  );

  hex_segment_reader #(.DIGITS(1)) dut1 (
    .clock(clock), .reset(reset1), .seg_in(seg_in1), .seg_valid(seg_valid1),
    .seg_ready(seg_ready1), .value(value1), .value_valid(value_valid1),
    .out_ready(out_ready1), .error(error1), .digit_count(digit_count1)
  );

  // Advance one rising edge; outputs are sampled 1 time unit afterwards.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Accept one digit (DUT is in COLLECT).
  task automatic feed(input logic [6:0] pat);
    seg_in = pat;
    seg_valid = 1'b1;
    step();
    seg_valid = 1'b0;
  endtask

  task automatic release_frame();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset1 = 1'b1;
    seg_valid = 1'b0; seg_in = 7'h7F; out_ready = 1'b0;
    seg_valid1 = 1'b0; seg_in1 = 7'h7F; out_ready1 = 1'b0;
    step(); step();
    reset = 1'b0; reset1 = 1'b0;
    checks++; if (seg_ready !== 1'b1) begin errors++; $display("FAIL reset_seg_ready got %b exp 1", seg_ready); end
    checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL reset_value_valid got %b exp 0", value_valid); end
    checks++; if (value !== 24'h0) begin errors++; $display("FAIL reset_value got %h exp 000000", value); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", error); end
    checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", digit_count); end
    $display("test_reset done");
  endtask

  task automatic test_collect();
    logic [6:0] pats [6];
    pats = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
    for (int i = 0; i < 6; i++) begin
      checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL collect_vv_early[%0d] got %b exp 0", i, value_valid); end
      feed(pats[i]);
      checks++; if (digit_count !== 3'(i + 1)) begin errors++; $display("FAIL collect_count[%0d] got %0d exp %0d", i, digit_count, i + 1); end
      if (i == 2) begin
        checks++; if (value !== 24'h000210) begin errors++; $display("FAIL collect_partial got %h exp 000210", value); end
      end
    end
    checks++; if (value_valid !== 1'b1) begin errors++; $display("FAIL collect_vv got %b exp 1", value_valid); end
    checks++; if (value !== 24'h543210) begin errors++; $display("FAIL collect_value got %h exp 543210", value); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL collect_error got %b exp 0", error); end
    $display("test_collect value=%h", value);
  endtask

  task automatic test_hold_and_error_frame();
    logic [6:0] pats [5];
    pats = '{7'h03, 7'h46, 7'h21, 7'h06, 7'h55};
    seg_in = 7'h08; seg_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (seg_ready !== 1'b0) begin errors++; $display("FAIL hold_seg_ready[%0d] got %b exp 0", i, seg_ready); end
      checks++; if (value !== 24'h543210) begin errors++; $display("FAIL hold_value[%0d] got %h exp 543210", i, value); end
      checks++; if (value_valid !== 1'b1 || digit_count !== 3'd6) begin errors++; $display("FAIL hold_state[%0d] got vv=%b cnt=%0d exp vv=1 cnt=6", i, value_valid, digit_count); end
    end
    // Release with seg_valid still high: no digit taken on the release edge.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL release_vv got %b exp 0", value_valid); end
    checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL release_count got %0d exp 0", digit_count); end
    checks++; if (value !== 24'h0) begin errors++; $display("FAIL release_value got %h exp 000000", value); end
    checks++; if (seg_ready !== 1'b1) begin errors++; $display("FAIL release_seg_ready got %b exp 1", seg_ready); end
    // Still-high 08 is accepted one cycle later as digit 0 of the next frame.
    step();
    seg_valid = 1'b0;
    checks++; if (digit_count !== 3'd1 || value !== 24'h00000A) begin errors++; $display("FAIL first_after_release got cnt=%0d val=%h exp cnt=1 val=00000A", digit_count, value); end
    for (int i = 0; i < 5; i++) feed(pats[i]);
    checks++; if (value !== 24'h0EDCBA) begin errors++; $display("FAIL errframe_value got %h exp 0EDCBA", value); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL errframe_error got %b exp 1", error); end
    release_frame();
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL errframe_clear got %b exp 0", error); end
    // out_ready high during COLLECT has no effect.
    out_ready = 1'b1;
    feed(7'h00); feed(7'h00);
    out_ready = 1'b0;
    checks++; if (digit_count !== 3'd2 || value !== 24'h000088) begin errors++; $display("FAIL collect_out_ready got cnt=%0d val=%h exp cnt=2 val=000088", digit_count, value); end
    for (int i = 0; i < 4; i++) feed(7'h00);
    checks++; if (value !== 24'h888888 || error !== 1'b0) begin errors++; $display("FAIL eights got val=%h err=%b exp 888888 0", value, error); end
    release_frame();
    $display("test_hold_and_error_frame done");
  endtask

  task automatic test_reset_mid();
    feed(7'h40); feed(7'h79); feed(7'h24);
    checks++; if (digit_count !== 3'd3) begin errors++; $display("FAIL mid_count_pre got %0d exp 3", digit_count); end
    reset = 1'b1; seg_valid = 1'b1; seg_in = 7'h30;
    step();
    reset = 1'b0; seg_valid = 1'b0;
    checks++; if (digit_count !== 3'd0 || value !== 24'h0) begin errors++; $display("FAIL mid_reset got cnt=%0d val=%h exp cnt=0 val=000000", digit_count, value); end
    // Reset beats a simultaneous release of a full frame.
    for (int i = 0; i < 6; i++) feed(7'h55);
    reset = 1'b1; out_ready = 1'b1;
    step();
    reset = 1'b0; out_ready = 1'b0;
    checks++; if (value_valid !== 1'b0 || error !== 1'b0 || digit_count !== 3'd0) begin errors++; $display("FAIL hold_reset got vv=%b err=%b cnt=%0d exp 0 0 0", value_valid, error, digit_count); end
    $display("test_reset_mid done");
  endtask

  task automatic test_blank();
    feed(7'h7F);
    for (int i = 0; i < 5; i++) feed(7'h40);
    checks++; if (value !== 24'h0 || value_valid !== 1'b1) begin errors++; $display("FAIL blank_value got val=%h vv=%b exp 000000 1", value, value_valid); end
    checks++; if (error !== BLANK_ERR) begin errors++; $display("FAIL blank_error got %b exp %b", error, BLANK_ERR); end
    release_frame();
    $display("test_blank error=%b", error);
  endtask

  task automatic test_digits1();
    seg_in1 = 7'h78; seg_valid1 = 1'b1; out_ready1 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k % 2 == 1) begin
        checks++; if (value_valid1 !== 1'b1 || value1 !== 4'h7) begin errors++; $display("FAIL d1_hold[%0d] got vv=%b val=%h exp 1 7", k, value_valid1, value1); end
      end else begin
        checks++; if (value_valid1 !== 1'b0 || value1 !== 4'h0) begin errors++; $display("FAIL d1_collect[%0d] got vv=%b val=%h exp 0 0", k, value_valid1, value1); end
      end
    end
    seg_valid1 = 1'b0; out_ready1 = 1'b0;
    $display("test_digits1 done");
  endtask

  initial begin
    #1;
    test_reset();
    test_collect();
    test_hold_and_error_frame();
    test_reset_mid();
    test_blank();
    test_digits1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_segment_reader.md
HEX_SEGMENT_READER -- requirements
Module: hex_segment_reader

Interface
REQ-001 Parameter: DIGITS, default 6, number of 7-segment digits assembled per frame (legal range 1..6).
REQ-002 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: seg_in  input  7  active-low segment pattern; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
REQ-005 Port: seg_valid  input  1  seg_in holds a digit this cycle.
REQ-006 Port: seg_ready  output  1  block accepts a digit this cycle.
REQ-007 Port: value  output  4*DIGITS  decoded frame; digit 0 (first accepted) in bits [3:0].
REQ-008 Port: value_valid  output  1  value and error are stable and offered downstream.
REQ-009 Port: out_ready  input  1  downstream accepts the frame.
REQ-010 Port: error  output  1  at least one digit in the offered frame was unrecognised.
REQ-011 Port: digit_count  output  3  digits accepted so far in the current frame.

Function
REQ-012 Decoding SHALL be the inverse of the team hex-display encoding, in hex: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-013 Any other pattern SHALL decode to nibble 0 and set the frame error flag.
REQ-014 FSM states: COLLECT and HOLD; reset enters COLLECT.
REQ-015 COLLECT: seg_ready=1, value_valid=0; a digit is accepted when seg_valid&&seg_ready at a rising edge.
REQ-016 An accepted digit SHALL be written to nibble position digit_count, then digit_count SHALL increment.
REQ-017 Accepting digit number DIGITS SHALL move the FSM to HOLD on the same edge; value_valid=1 from the next cycle (one-cycle latency from the last accept).
REQ-018 HOLD: seg_ready=0; value, error and digit_count (=DIGITS) SHALL stay frozen; seg_valid is ignored.
REQ-019 HOLD with out_ready=1 at an edge completes the transfer: return to COLLECT, digit_count=0, value cleared to 0, error cleared.
REQ-020 The block SHALL NOT accept a digit on the edge the frame is released; the first new digit can be accepted one cycle later.
REQ-021 out_ready while in COLLECT SHALL have no effect.
REQ-022 The error flag SHALL be sticky across a frame: set by any unrecognised digit, cleared only by frame release or reset.
REQ-023 value_valid SHALL depend only on state (registered), not combinationally on out_ready or seg_valid.

Reset
REQ-024 When reset=1 at an edge: state=COLLECT, value=0, error=0, digit_count=0, value_valid=0, seg_ready=1 from the next cycle.
REQ-025 Reset SHALL take priority over any simultaneous accept or release; a partial frame or an unreleased frame is discarded.

Configuration
REQ-026 Macro HEX_SEGMENT_READER_BLANK_EN: when defined, pattern 7F (all segments off) SHALL be accepted as nibble 0 without setting error.
REQ-027 Without HEX_SEGMENT_READER_BLANK_EN, pattern 7F SHALL be treated as unrecognised per REQ-013.

Verification
REQ-028 DIGITS=6; feed 40,79,24,30,19,12 back-to-back with out_ready=0 -> value=24'h543210, error=0, value_valid=1 one cycle after the sixth accept, held until out_ready.
REQ-029 In HOLD, drive seg_valid=1 with 08 for 5 cycles -> seg_ready=0, value unchanged; assert out_ready -> next cycle value_valid=0, digit_count=0, value=0.
REQ-030 Frame 08,03,46,21,06,55 -> value=24'h0EDCBA, error=1; next frame of six 00 -> value=24'h888888, error=0.
REQ-031 Accept three digits, assert reset one cycle together with seg_valid -> digit_count=0, value=0, no digit accepted that cycle.
REQ-032 Feed 7F as digit 0 followed by five 40 -> with macro: value=0, error=0; without macro: value=0, error=1.
REQ-033 DIGITS=1; seg_valid held high with 78 and out_ready held high -> value_valid pulses one cycle in every two, value=4'h7 each time.
